// File: rtl/vector_sequencer.sv
// vector_sequencer: applies directed vectors to a DUT, waits a bounded time
// for its done flag, compares the masked result and emits one event record
// per vector on a valid/ready log stream.
module vector_sequencer #(
    parameter int DRIVE_W = 8,
    parameter int LOAD_W  = 8,
    parameter int CYCLE_W = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [DRIVE_W-1:0] vec_drive,
    input  logic [LOAD_W-1:0]  vec_expect,
    input  logic [LOAD_W-1:0]  vec_mask,
    input  logic               vec_last,
    output logic [DRIVE_W-1:0] dut_in,
    output logic               dut_start,
    input  logic               dut_done,
    input  logic [LOAD_W-1:0]  dut_out,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_level,
    output logic               evt_kind,
    output logic [CYCLE_W-1:0] evt_cycles,
    output logic [LOAD_W-1:0]  evt_received,
    output logic [LOAD_W-1:0]  evt_expected,
    output logic [CYCLE_W-1:0] pass_count,
    output logic [CYCLE_W-1:0] fail_count,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, REPORT, FINISH} state_t;

    localparam logic [2:0]         LVL_INFO  = 3'd2;
    localparam logic [2:0]         LVL_ERROR = 3'd4;
    localparam logic               KIND_EQ   = 1'b0;
    localparam logic               KIND_MON  = 1'b1;
    localparam logic [CYCLE_W-1:0] TO_CNT    = CYCLE_W'(TIMEOUT);
    localparam logic [CYCLE_W-1:0] ONE       = CYCLE_W'(1);

    state_t             state, state_nxt;
    logic [LOAD_W-1:0]  exp_r, mask_r;
    logic               last_r;
    logic [CYCLE_W-1:0] cnt;
    logic               mismatch;

    assign mismatch  = |((dut_out ^ exp_r) & mask_r);
    assign vec_ready = (state == IDLE);
    assign dut_start = (state == APPLY);
    assign evt_valid = (state == REPORT);
    assign done      = (state == FINISH);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; the only input-dependent exits are accept, done/timeout and log handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vec_valid) state_nxt = APPLY;
            APPLY:   state_nxt = WAIT;
            WAIT:    if (dut_done || cnt == TO_CNT) state_nxt = REPORT;
            REPORT:  if (evt_ready) state_nxt = last_r ? FINISH : IDLE;
            FINISH:  state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector capture, wait counter, result latch and saturating pass/fail counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in       <= '0;
            exp_r        <= '0;
            mask_r       <= '0;
            last_r       <= 1'b0;
            cnt          <= '0;
            evt_level    <= '0;
            evt_kind     <= 1'b0;
            evt_cycles   <= '0;
            evt_received <= '0;
            evt_expected <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
        end else begin
            case (state)
                IDLE: if (vec_valid) begin
                    dut_in <= vec_drive;
                    exp_r  <= vec_expect;
                    mask_r <= vec_mask;
                    last_r <= vec_last;
                end
                APPLY: cnt <= '0;
                WAIT: begin
                    if (dut_done) begin
                        evt_received <= dut_out;
                        evt_expected <= exp_r;
                        evt_cycles   <= cnt;
                        evt_kind     <= KIND_EQ;
                        evt_level    <= mismatch ? LVL_ERROR : LVL_INFO;
                    end else if (cnt == TO_CNT) begin
                        evt_received <= dut_out;
                        evt_expected <= exp_r;
                        evt_cycles   <= TO_CNT;
                        evt_kind     <= KIND_MON;
                        evt_level    <= LVL_ERROR;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                REPORT: if (evt_ready) begin
                    if (evt_level == LVL_INFO && pass_count != '1)
                        pass_count <= pass_count + ONE;
                    if (evt_level == LVL_ERROR && fail_count != '1)
                        fail_count <= fail_count + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: a stimulus process issues vectors and pushes the
// expected record; a responder plays the DUT; a monitor checks every record.
module tb_vector_sequencer;

    localparam int DW = 8, LW = 8, CW = 16, TO = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          vec_valid, vec_ready, vec_last;
    logic [DW-1:0] vec_drive, dut_in;
    logic [LW-1:0] vec_expect, vec_mask, dut_out;
    logic          dut_start, dut_done, evt_valid, evt_ready, evt_kind, done;
    logic [2:0]    evt_level;
    logic [CW-1:0] evt_cycles, pass_count, fail_count;
    logic [LW-1:0] evt_received, evt_expected;

    vector_sequencer #(.DRIVE_W(DW), .LOAD_W(LW), .CYCLE_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_drive(vec_drive), .vec_expect(vec_expect), .vec_mask(vec_mask),
        .vec_last(vec_last), .dut_in(dut_in), .dut_start(dut_start),
        .dut_done(dut_done), .dut_out(dut_out), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_level(evt_level), .evt_kind(evt_kind),
        .evt_cycles(evt_cycles), .evt_received(evt_received),
        .evt_expected(evt_expected), .pass_count(pass_count),
        .fail_count(fail_count), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    level;
        logic          kind;
        int            cycles;
        logic [LW-1:0] received;
        logic [LW-1:0] expected;
        logic [DW-1:0] drive;
        int            lat;
        bit            last;
    } exp_t;

    typedef struct {
        int            d;      // done asserted d cycles after start; 0 = never
        logic [LW-1:0] out;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0;
    int    handshakes = 0;
    int    bp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected record from the plain rules: done seen at wait count d-1 if that
    // count is within the window, otherwise a timeout after TO+1 looks.
    function automatic exp_t ref_model(input logic [DW-1:0] drv, input logic [LW-1:0] ex,
                                       input logic [LW-1:0] mk, input bit lst,
                                       input int d, input logic [LW-1:0] out);
        exp_t e;
        e.drive = drv; e.expected = ex; e.received = out; e.last = lst;
        if (d >= 1 && d - 1 <= TO) begin
            e.kind = 1'b0; e.cycles = d - 1; e.lat = d + 1;
            e.level = (((out ^ ex) & mk) != 0) ? 3'd4 : 3'd2;
        end else begin
            e.kind = 1'b1; e.cycles = TO; e.lat = TO + 2; e.level = 3'd4;
        end
        return e;
    endfunction

    // DUT responder: on start, present the planned result and pulse done d cycles later.
    initial begin
        int d, cnt;
        bit active;
        plan_t p;
        d = 0; cnt = 0; active = 0;
        dut_done = 1'b0; dut_out = '0;
        forever begin
            @(negedge clk);
            dut_done = 1'b0;
            if (!rst_n) active = 0;
            else if (dut_start) begin
                d = 0;
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front(); d = p.d; dut_out = p.out;
                end
                cnt = 0; active = (d != 0);
                dut_done = 1'($urandom_range(0, 1)); // must be ignored during start
            end else if (active) begin
                cnt++;
                if (cnt == d) begin dut_done = 1'b1; active = 0; end
            end
        end
    end

    // Log sink: random readiness, with forced stalls when bp_cnt is loaded.
    initial begin
        evt_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (evt_valid && bp_cnt > 0) begin evt_ready = 1'b0; bp_cnt--; end
            else evt_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each presented record and the running counters.
    initial begin
        exp_t e;
        int   start_cyc, exp_pass, exp_fail;
        bit   prev_v, prev_start, exp_done;
        start_cyc = 0; exp_pass = 0; exp_fail = 0;
        prev_v = 0; prev_start = 0; exp_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pass = 0; exp_fail = 0; exp_done = 0; prev_v = 0; prev_start = 0;
                continue;
            end
            chk("pass_count", pass_count, exp_pass);
            chk("fail_count", fail_count, exp_fail);
            chk("done", done, exp_done);
            if (done) chk("vec_ready_finish", vec_ready, 0);
            if (dut_start) begin
                start_cyc = cyc;
                chk("start_pulse", prev_start, 0);
                if (exp_q.size() > 0) chk("dut_in", dut_in, exp_q[0].drive);
            end
            prev_start = dut_start;
            if (evt_valid) begin
                chk("vec_ready_report", vec_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_record actual level %0d required none", evt_level);
                end else begin
                    e = exp_q[0];
                    if (!prev_v) chk("evt_latency", cyc - start_cyc, e.lat);
                    chk("evt_level", evt_level, e.level);
                    chk("evt_kind", evt_kind, e.kind);
                    chk("evt_cycles", evt_cycles, e.cycles);
                    chk("evt_received", evt_received, e.received);
                    chk("evt_expected", evt_expected, e.expected);
                    if (evt_ready) begin
                        void'(exp_q.pop_front());
                        handshakes++;
                        if (e.level == 3'd2 && exp_pass < 65535) exp_pass++;
                        if (e.level == 3'd4 && exp_fail < 65535) exp_fail++;
                        if (e.last) exp_done = 1;
                    end
                end
            end
            prev_v = evt_valid && !evt_ready;
        end
    end

    task automatic send(input logic [DW-1:0] drv, input logic [LW-1:0] ex, input logic [LW-1:0] mk,
                        input bit lst, input int d, input logic [LW-1:0] out);
        int budget;
        plan_t p;
        budget = 0;
        @(negedge clk);
        while (!vec_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual vec_ready 0 required 1");
                return;
            end
        end
        vec_valid = 1'b1; vec_drive = drv; vec_expect = ex; vec_mask = mk; vec_last = lst;
        p.d = d; p.out = out;
        plan_q.push_back(p);
        exp_q.push_back(ref_model(drv, ex, mk, lst, d, out));
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin @(negedge clk); budget++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        int            hs0, budget, r, d;
        logic [LW-1:0] ex, mk, out;
        vec_valid = 1'b0; vec_drive = '0; vec_expect = '0; vec_mask = '0; vec_last = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec_ready", vec_ready, 1);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_start_valid_done", {dut_start, evt_valid, done}, 0);
        chk("rst_evt_fields", {evt_level, evt_kind, evt_cycles, evt_received, evt_expected}, 0);
        chk("rst_counters", {pass_count, fail_count}, 0);
        rst_n = 1'b1;

        // Directed cases.
        send(8'h3C, 8'hA5, 8'hFF, 0, 3, 8'hA5);    // match, cycles 2
        send(8'h11, 8'hA5, 8'hFE, 0, 2, 8'hA4);    // masked-off mismatch -> INFO
        send(8'h12, 8'hA5, 8'h01, 0, 5, 8'hA4);    // compared mismatch -> ERROR
        send(8'h13, 8'h5A, 8'hFF, 0, 0, 8'h77);    // no done -> MONITOR timeout
        send(8'h14, 8'h5A, 8'hFF, 0, TO + 1, 8'h5A); // done at c = TIMEOUT
        send(8'h15, 8'hFF, 8'h00, 0, 1, 8'h00);    // mask 0 always INFO
        drain();
        bp_cnt = 5;
        send(8'h16, 8'hC3, 8'hF0, 0, 4, 8'hC0);    // stalled log sink
        drain();

        // Randomized vectors.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = (r < 2) ? 0 : (r < 3) ? TO + 3 : $urandom_range(1, TO + 1);
            ex = 8'($urandom);
            r = $urandom_range(0, 2);
            mk = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
            out = ($urandom_range(0, 1) != 0) ? ex : 8'($urandom);
            if ($urandom_range(0, 7) == 0) bp_cnt = $urandom_range(1, 6);
            send(8'($urandom), ex, mk, 0, d, out);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Asynchronous reset while waiting for done.
        send(8'h99, 8'h42, 8'hFF, 0, 0, 8'h00);
        budget = 0;
        while (!dut_start && budget < 50) begin @(negedge clk); budget++; end
        chk("mid_reset_saw_start", dut_start, 1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_reset_evt_valid", evt_valid, 0);
        chk("mid_reset_dut_in", dut_in, 0);
        chk("mid_reset_counters", {pass_count, fail_count}, 0);
        chk("mid_reset_vec_ready", vec_ready, 1);
        chk("mid_reset_dut_start", dut_start, 0);
        exp_q.delete(); plan_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h5E, 8'h81, 8'hFF, 0, 2, 8'h81);
        drain();

        // Run end: three vectors, last on the third, then vec_valid held high.
        hs0 = handshakes;
        send(8'h01, 8'h10, 8'hFF, 0, 2, 8'h10);
        send(8'h02, 8'h20, 8'hFF, 0, 3, 8'h21);
        send(8'h03, 8'h30, 8'h0F, 1, 1, 8'h30);
        vec_valid = 1'b1; vec_last = 1'b0;
        budget = 0;
        while (!done && budget < 300) begin @(negedge clk); budget++; end
        chk("run_done", done, 1);
        repeat (20) begin
            @(negedge clk);
            chk("finish_quiet", {vec_ready, dut_start, evt_valid}, 0);
        end
        chk("run_records", handshakes - hs0, 3);
        chk("run_pending", exp_q.size(), 0);
        vec_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
